// File: rtl/ledg_pattern_sequencer.sv
// rtl/ledg_pattern_sequencer.sv - Avalon-MM pattern table player driving the green-LED PIO.
// CPU programs table/interval/control on the slave port; the FSM replays entries as master writes.
module ledg_pattern_sequencer #(
  parameter int DATA_W   = 9,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 24,
  parameter int PIO_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   table_q [DEPTH];
  logic                run_q, loop_q, done_q;
  logic [2:0]          last_q;
  logic [CNT_W-1:0]    interval_q, cnt_q, cnt_d, load_cnt;
  logic [IDX_W-1:0]    index_q, index_d, next_idx, last_idx;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_en, ctrl_wr, abort, done_set, tab_ok, unused_wd;

  assign wr_en    = chipselect & ~write_n;
  assign ctrl_wr  = wr_en && (address == 4'd0);
  assign abort    = ctrl_wr && !writedata[0];
  assign tab_ok   = address[3] && ({1'b0, address[2:0]} < DEPTH_L);
  assign last_idx = last_q[IDX_W-1:0];
  assign next_idx = index_q + 1'b1;
  // An interval of 0 behaves as 1 so every step has at least one WAIT cycle.
  assign load_cnt = (interval_q == '0) ? '0 : interval_q - 1'b1;
  assign unused_wd = ^writedata;

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    done_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && writedata[0]) begin
          state_d = S_WRITE;
          index_d = '0;
          wdata_d = table_q[0];
        end
      end
      S_WRITE: begin
        // A pending abort still lets the outstanding PIO write complete.
        if (!avm_waitrequest) begin
          if (abort || !run_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = load_cnt;
          end
        end
      end
      S_WAIT: begin
        if (abort || !run_q) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (index_q != last_idx) begin
          state_d = S_WRITE;
          index_d = next_idx;
          wdata_d = table_q[next_idx];
        end else if (loop_q) begin
          state_d = S_WRITE;
          index_d = '0;
          wdata_d = table_q[0];
        end else begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      loop_q     <= 1'b0;
      last_q     <= '0;
      done_q     <= 1'b0;
      interval_q <= '0;
      cnt_q      <= '0;
      index_q    <= '0;
      wdata_q    <= '0;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      if (ctrl_wr) begin
        loop_q <= writedata[1];
        last_q <= writedata[6:4];
      end
      // Completion clears run and sets done, winning over a same-cycle CPU write.
      if (done_set) run_q <= 1'b0;
      else if (ctrl_wr) run_q <= writedata[0];
      if (done_set) done_q <= 1'b1;
      else if (wr_en && address == 4'd1 && writedata[8]) done_q <= 1'b0;
      if (wr_en && address == 4'd2) interval_q <= writedata[CNT_W-1:0];
      if (wr_en && tab_ok) table_q[address[IDX_W-1:0]] <= writedata[DATA_W-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      4'd0: readdata = {25'b0, last_q, 2'b00, loop_q, run_q};
      4'd1: readdata = {23'b0, done_q, 1'b0, 3'(index_q), 3'b000, busy};
      4'd2: readdata = 32'(interval_q);
      default: if (tab_ok) readdata = 32'(table_q[address[IDX_W-1:0]]);
    endcase
  end

  assign avm_address    = 2'(PIO_ADDR);
  assign avm_chipselect = (state_q == S_WRITE);
  assign avm_write_n    = (state_q != S_WRITE);
  assign avm_writedata  = 32'(wdata_q);
  assign busy           = (state_q != S_IDLE);

endmodule
